fft_frame_buffer: RTL and testbench

Upstream feeder for `FFT_Processor`.
- Collects a continuous stream of 16-bit audio samples into 16-sample frames.
- Presents each completed frame on `t0`..`t15`, held stable, with a one-cycle `new_t` strobe.
- Holds the frame until the FFT reports `done`.
- Drops, and counts, frames that complete while the FFT is still busy, so the audio stream is never stalled.

---
 rtl/fft_frame_buffer.sv | 81 ++++++++
 tb/tb_fft_frame_buffer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_buffer.sv
// fft_frame_buffer: gathers decimated 16-bit audio samples into 16-sample frames for an FFT,
// holding each launched frame until released and dropping/counting frames that arrive while busy.
module fft_frame_buffer #(
  parameter int DECIM = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  input  logic        fft_done,
  output logic [15:0] t0,
  output logic [15:0] t1,
  output logic [15:0] t2,
  output logic [15:0] t3,
  output logic [15:0] t4,
  output logic [15:0] t5,
  output logic [15:0] t6,
  output logic [15:0] t7,
  output logic [15:0] t8,
  output logic [15:0] t9,
  output logic [15:0] t10,
  output logic [15:0] t11,
  output logic [15:0] t12,
  output logic [15:0] t13,
  output logic [15:0] t14,
  output logic [15:0] t15,
  output logic        new_t,
  output logic        fft_busy,
  output logic        overrun,
  output logic [7:0]  drop_count
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [7:0] RELOAD = 8'(DECIM - 1);
  state_t state, state_nxt;
  logic [15:0] fill [16];
  logic [15:0] hold [16];
  logic [3:0]  wp;
  logic [7:0]  dcnt;
  logic        accept, complete, launch, drop;
  assign accept = sample_valid && dcnt == 8'd0;
  assign complete = accept && wp == 4'd15;
  assign fft_busy = state == BUSY;
  // a release coinciding with a completed frame relaunches instead of dropping
  always_comb begin
    launch = complete && (state == IDLE || fft_done);
    drop = complete && state == BUSY && !fft_done;
    state_nxt = (launch || (state == BUSY && !fft_done)) ? BUSY : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      dcnt <= '0;
      new_t <= 1'b0;
      overrun <= 1'b0;
      drop_count <= '0;
      for (int i = 0; i < 16; i++) begin
        fill[i] <= '0;
        hold[i] <= '0;
      end
    end else begin
      new_t <= launch;
      overrun <= drop;
      if (drop && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
      if (sample_valid) dcnt <= accept ? RELOAD : dcnt - 8'd1;
      if (accept) begin
        fill[wp] <= sample_in;
        wp <= wp + 4'd1;
      end
      // the completing sample bypasses fill[15], which is only written on this same edge
      if (launch) begin
        for (int i = 0; i < 15; i++) hold[i] <= fill[i];
        hold[15] <= sample_in;
      end
    end
  assign {t15, t14, t13, t12, t11, t10, t9, t8, t7, t6, t5, t4, t3, t2, t1, t0} =
    {hold[15], hold[14], hold[13], hold[12], hold[11], hold[10], hold[9], hold[8],
     hold[7], hold[6], hold[5], hold[4], hold[3], hold[2], hold[1], hold[0]};
endmodule

// File: tb/tb_fft_frame_buffer.sv
// tb_fft_frame_buffer: vector table plus frame scoreboard for fft_frame_buffer (DECIM 1 and 3).
module tb_fft_frame_buffer;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] sa = '0, sb = '0;
  logic va = 1'b0, vb = 1'b0, da = 1'b0, db = 1'b0;
  logic [15:0] at [16];
  logic [15:0] bt [16];
  logic an, ab, ao, bn, bb, bo;
  logic [7:0] adc, bdc;
  logic [255:0] fa_v, fb_v;
  logic [255:0] qa [$];
  logic [255:0] qb [$];
  int vectors = 0, miscompares = 0, a_new = 0, a_ovr = 0, b_new = 0;
  int base_new, base_ovr, n;
  logic g;
  typedef struct {logic [15:0] s; logic v, d, en, eb, eo; logic [7:0] dc;} vec_t;
  vec_t tbl [19];
  logic [255:0] f1;

  always #5 clk = ~clk;

  fft_frame_buffer #(.DECIM(1)) dut_a (
    .clk(clk), .rst(rst), .sample_in(sa), .sample_valid(va), .fft_done(da),
    .t0(at[0]), .t1(at[1]), .t2(at[2]), .t3(at[3]), .t4(at[4]), .t5(at[5]),
    .t6(at[6]), .t7(at[7]), .t8(at[8]), .t9(at[9]), .t10(at[10]), .t11(at[11]),
    .t12(at[12]), .t13(at[13]), .t14(at[14]), .t15(at[15]),
    .new_t(an), .fft_busy(ab), .overrun(ao), .drop_count(adc));

  fft_frame_buffer #(.DECIM(3)) dut_b (
    .clk(clk), .rst(rst), .sample_in(sb), .sample_valid(vb), .fft_done(db),
    .t0(bt[0]), .t1(bt[1]), .t2(bt[2]), .t3(bt[3]), .t4(bt[4]), .t5(bt[5]),
    .t6(bt[6]), .t7(bt[7]), .t8(bt[8]), .t9(bt[9]), .t10(bt[10]), .t11(bt[11]),
    .t12(bt[12]), .t13(bt[13]), .t14(bt[14]), .t15(bt[15]),
    .new_t(bn), .fft_busy(bb), .overrun(bo), .drop_count(bdc));

  always_comb begin
    fa_v = '0;
    fb_v = '0;
    for (int i = 0; i < 16; i++) begin
      fa_v[i*16 +: 16] = at[i];
      fb_v[i*16 +: 16] = bt[i];
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] seqf(input int base, input int st);
    seqf = '0;
    for (int i = 0; i < 16; i++) seqf[i*16 +: 16] = 16'(base + i * st);
  endfunction

  task automatic step(input logic [15:0] s, input logic v, input logic d);
    sa = s; va = v; da = d;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) if (!rst) begin
    if (an || ao) chk("a_strobe_excl", 256'(an & ao), 0);
    if (ao) a_ovr++;
    if (an) begin
      a_new++;
      chk("a_launch_expected", 256'(qa.size() != 0), 1);
      if (qa.size() != 0) chk("a_frame", fa_v, qa.pop_front());
    end
    if (bn) begin
      b_new++;
      chk("b_launch_expected", 256'(qb.size() != 0), 1);
      if (qb.size() != 0) chk("b_frame", fb_v, qb.pop_front());
    end
  end

  initial begin
    f1 = '0;
    for (int i = 0; i < 16; i++) begin
      f1[i*16 +: 16] = (i % 2 == 0) ? 16'd10 : 16'd0;
      tbl[i] = '{(i % 2 == 0) ? 16'd10 : 16'd0, 1'b1, 1'b0, 1'(i == 15), 1'(i == 15), 1'b0, 8'd0};
    end
    tbl[16] = '{16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[17] = '{16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[18] = '{16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

    @(posedge clk); #1;
    chk("rst_frame", fa_v, 0);
    chk("rst_new_t", 256'(an), 0);
    chk("rst_busy", 256'(ab), 0);
    chk("rst_overrun", 256'(ao), 0);
    chk("rst_drop", 256'(adc), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      if (i == 15) qa.push_back(f1);
      step(tbl[i].s, tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d_new_t", i), 256'(an), 256'(tbl[i].en));
      chk($sformatf("vec%0d_busy", i), 256'(ab), 256'(tbl[i].eb));
      chk($sformatf("vec%0d_overrun", i), 256'(ao), 256'(tbl[i].eo));
      chk($sformatf("vec%0d_drop", i), 256'(adc), 256'(tbl[i].dc));
    end
    chk("single_hold", fa_v, f1);

    n = 0;
    while (n < 48) begin
      g = ($urandom_range(3) == 0);
      if (!g && n == 45) qb.push_back(seqf(0, 3));
      sb = g ? 16'hdead : 16'(n);
      vb = !g;
      @(posedge clk); #1;
      if (!g) n++;
    end
    vb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("decim_launches", 256'(b_new), 1);
    chk("decim_hold", fb_v, seqf(0, 3));
    chk("decim_busy", 256'(bb), 1);

    base_new = a_new; base_ovr = a_ovr;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) qa.push_back(seqf(100, 1));
      step(16'(100 + i), 1'b1, 1'b0);
    end
    for (int i = 0; i < 32; i++) step(16'(200 + i), 1'b1, 1'b0);
    step(16'd0, 1'b0, 1'b0);
    chk("ovr_pulses", 256'(a_ovr - base_ovr), 2);
    chk("ovr_launches", 256'(a_new - base_new), 1);
    chk("ovr_drop", 256'(adc), 2);
    chk("ovr_hold", fa_v, seqf(100, 1));
    chk("ovr_busy", 256'(ab), 1);

    for (int i = 0; i < 16; i++) begin
      if (i == 15) qa.push_back(seqf(400, 1));
      step(16'(400 + i), 1'b1, 1'(i == 15));
      if (i == 15) begin
        chk("coinc_new_t", 256'(an), 1);
        chk("coinc_overrun", 256'(ao), 0);
        chk("coinc_busy", 256'(ab), 1);
        chk("coinc_drop", 256'(adc), 2);
        chk("coinc_hold", fa_v, seqf(400, 1));
      end
    end
    step(16'd0, 1'b0, 1'b1);
    chk("done_on_new_t_busy", 256'(ab), 0);
    step(16'd0, 1'b0, 1'b0);

    for (int i = 0; i < 9; i++) step(16'(600 + i), 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_frame", fa_v, 0);
    chk("mid_rst_busy", 256'(ab), 0);
    chk("mid_rst_drop", 256'(adc), 0);
    chk("mid_rst_new_t", 256'(an), 0);
    chk("mid_rst_b_frame", fb_v, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    base_new = a_new;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) qa.push_back(seqf(700, 1));
      step(16'(700 + i), 1'b1, 1'b0);
    end
    step(16'd0, 1'b0, 1'b1);
    chk("post_rst_launches", 256'(a_new - base_new), 1);
    chk("post_rst_hold", fa_v, seqf(700, 1));

    for (int i = 0; i < 16; i++) begin
      if (i == 15) qa.push_back(seqf(800, 1));
      step(16'(800 + i), 1'b1, 1'b0);
    end
    base_ovr = a_ovr;
    for (int j = 0; j < 260 * 16; j++) step(16'(j), 1'b1, 1'b0);
    step(16'd0, 1'b0, 1'b0);
    chk("sat_pulses", 256'(a_ovr - base_ovr), 260);
    chk("sat_drop", 256'(adc), 255);
    chk("sat_hold", fa_v, seqf(800, 1));
    step(16'd0, 1'b0, 1'b1);
    chk("sat_release", 256'(ab), 0);

    chk("a_queue_empty", 256'(qa.size()), 0);
    chk("b_queue_empty", 256'(qb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
